// File: rtl/pipe_seq.sv
// Sequencer for the two-stage 16-bit pipeline: owns pc, ir0q, ir1q and the shared
// memory port. It alternates decode, optional data access and fetch, and guards each access with a timeout.
module pipe_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 15,
  parameter int          WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        sel_addr_reg,
  input  logic        dec_rw,
  input  logic        dojump,
  input  logic        clr_ir0,
  input  logic [15:0] jump_target,
  input  logic [15:0] addr_reg,
  input  logic [15:0] alu_out,
  output logic [15:0] ir0q,
  output logic [15:0] ir1q,
  output logic [15:0] pc,
  output logic [15:0] mdr,
  output logic        step,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_DEC, S_DATA, S_FETCH, S_ERR} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              at_limit;

  // The cycle that would bring wait_cnt to TIMEOUT is the last one allowed; an ack in it still wins.
  assign at_limit = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_DEC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_DEC:   state_nxt = sel_addr_reg ? S_DATA : S_FETCH;
      S_DATA: begin
        if (mem_ack)       state_nxt = S_FETCH;
        else if (at_limit) state_nxt = S_ERR;
      end
      S_FETCH: begin
        if (mem_ack)       state_nxt = S_DEC;
        else if (at_limit) state_nxt = S_ERR;
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_DEC;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_rw    = 1'b1;
    mem_addr  = pc;
    mem_wdata = '0;
    step      = 1'b0;
    bus_err   = 1'b0;
    case (state)
      S_DATA: begin
        mem_req   = 1'b1;
        mem_addr  = addr_reg;
        mem_rw    = dec_rw;
        mem_wdata = alu_out;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        step    = mem_ack;
      end
      S_ERR:   bus_err = 1'b1;
      default: ;
    endcase
  end

  // Counter restarts whenever the state changes, so each access gets its own budget.
  always_ff @(posedge clk) begin
    if (reset || !mem_req || (state_nxt != state)) begin
      wait_cnt <= '0;
    end else if (!mem_ack) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= RESET_PC;
      ir0q <= '0;
      ir1q <= '0;
      mdr  <= '0;
    end else begin
      if ((state == S_DATA) && mem_ack && dec_rw) begin
        mdr <= mem_rdata;
      end
      if (step) begin
        ir1q <= ir0q;
        if (dojump) begin
          pc   <= jump_target;
          ir0q <= '0;
        end else if (clr_ir0) begin
          ir0q <= '0;
        end else begin
          ir0q <= mem_rdata;
          pc   <= pc + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_seq.sv
// Bench for pipe_seq: a transaction-level model of the pipeline registers and bus rules
// is checked every cycle, alongside directed steps with hand-computed expectations.
module tb_pipe_seq;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_rw, step, bus_err;
  logic [15:0] mem_addr, mem_wdata, ir0q, ir1q, pc, mdr;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        sel_addr_reg = 1'b0, dec_rw = 1'b1, dojump = 1'b0, clr_ir0 = 1'b0;
  logic [15:0] jump_target = '0, addr_reg = '0, alu_out = '0;

  pipe_seq #(.RESET_PC(16'h0000), .TIMEOUT(TIMEOUT), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .sel_addr_reg(sel_addr_reg), .dec_rw(dec_rw), .dojump(dojump), .clr_ir0(clr_ir0),
    .jump_target(jump_target), .addr_reg(addr_reg), .alu_out(alu_out),
    .ir0q(ir0q), .ir1q(ir1q), .pc(pc), .mdr(mdr), .step(step), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_fail = 0;
  int cyc = 0, t0 = 0;
  bit armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: explicit words, otherwise address xor A5A5.
  logic [15:0] memv [int];
  function automatic logic [15:0] rd(input logic [15:0] a);
    if (memv.exists(int'(a))) return memv[int'(a)];
    return a ^ 16'hA5A5;
  endfunction

  int lat = 0, rcnt = 0;
  bit ack_en = 1'b1, ack_force = 1'b0;

  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (ack_force) begin
      mem_ack = 1'b1;
      rcnt = 0;
    end else if (mem_req && ack_en) begin
      if (rcnt >= lat) begin
        mem_ack = 1'b1;
        rcnt = 0;
        if (mem_rw) mem_rdata = rd(mem_addr);
        else memv[int'(mem_addr)] = mem_wdata;
      end else begin
        rcnt++;
      end
    end else begin
      rcnt = 0;
    end
  end

  // Architectural model: after reset or a step one idle decode cycle, then the bus is
  // requested continuously (data access first if the decoder asks) until the fetch completes.
  logic [15:0] m_pc = '0, m_ir0 = '0, m_ir1 = '0, m_mdr = '0;
  bit m_err = 1'b0, m_dec = 1'b1, m_data_done = 1'b0;
  int m_wait = 0;

  always @(negedge clk) begin : model
    logic is_data, exp_req, exp_step;
    is_data  = sel_addr_reg && !m_data_done;
    exp_req  = !m_dec && !m_err;
    exp_step = exp_req && mem_ack && !is_data;
    if (armed) begin
      chk("pc", pc, m_pc);
      chk("ir0q", ir0q, m_ir0);
      chk("ir1q", ir1q, m_ir1);
      chk("mdr", mdr, m_mdr);
      chk("bus_err", {15'd0, bus_err}, {15'd0, m_err});
      chk("mem_req", {15'd0, mem_req}, {15'd0, exp_req});
      chk("step", {15'd0, step}, {15'd0, exp_step});
      if (exp_req) begin
        chk("mem_addr", mem_addr, is_data ? addr_reg : m_pc);
        chk("mem_rw", {15'd0, mem_rw}, {15'd0, (is_data ? dec_rw : 1'b1)});
        if (is_data && !dec_rw) chk("mem_wdata", mem_wdata, alu_out);
      end
    end
    if (reset) begin
      m_pc = '0; m_ir0 = '0; m_ir1 = '0; m_mdr = '0;
      m_err = 1'b0; m_dec = 1'b1; m_data_done = 1'b0; m_wait = 0;
    end else if (exp_req) begin
      if (mem_ack) begin
        m_wait = 0;
        if (is_data) begin
          if (dec_rw) m_mdr = mem_rdata;
          m_data_done = 1'b1;
        end else begin
          m_ir1 = m_ir0;
          if (dojump) begin
            m_pc = jump_target; m_ir0 = '0;
          end else if (clr_ir0) begin
            m_ir0 = '0;
          end else begin
            m_ir0 = mem_rdata; m_pc = m_pc + 16'd1;
          end
          m_data_done = 1'b0;
          m_dec = 1'b1;
        end
      end else begin
        m_wait++;
        if (m_wait >= TIMEOUT) m_err = 1'b1;
      end
    end else begin
      m_dec = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    t0 = cyc;
  endtask

  // Holds decoder inputs for one step; returns the cycle (1 = first after reset) of the step strobe.
  task automatic do_step(input logic sel, input logic rw, input logic jmp, input logic clr,
                         input logic [15:0] tgt, input logic [15:0] addr, input logic [15:0] alu,
                         output int scyc);
    sel_addr_reg = sel; dec_rw = rw; dojump = jmp; clr_ir0 = clr;
    jump_target = tgt; addr_reg = addr; alu_out = alu;
    scyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        scyc = cyc - t0 + 1;
        break;
      end
    end
    if (scyc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL step_timeout: got no step expected step within 60 cycles");
    end
    @(posedge clk); #2;
  endtask

  initial begin : stim
    int sc, prev, ec;
    logic [15:0] w [4];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444;

    // Reset, zero-wait fetch of 1234 at address 0.
    memv[0] = 16'h1234;
    lat = 0;
    do_reset();
    armed = 1'b1;
    do_step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, sc);
    chk("t1_step_cycle", 16'(sc), 16'd2);
    chk("t1_pc", pc, 16'h0001);
    chk("t1_ir0", ir0q, 16'h1234);
    chk("t1_ir1", ir1q, 16'h0000);
    chk("t1_model_ir0", m_ir0, 16'h1234);

    // Straight-line fetch with 3 wait states.
    for (int k = 0; k < 4; k++) memv[k] = w[k];
    do_reset();
    lat = 3;
    prev = 0;
    for (int k = 1; k <= 4; k++) begin
      do_step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, sc);
      chk("t2_period", 16'(sc - prev), 16'd5);
      chk("t2_pc", pc, 16'(k));
      chk("t2_ir0", ir0q, w[k-1]);
      chk("t2_ir1", ir1q, (k > 1) ? w[k-2] : 16'h0000);
      prev = sc;
    end
    chk("t2_model_pc", m_pc, 16'h0004);

    // Load then store via r2.
    lat = 0;
    memv[16'h0080] = 16'hBEEF;
    do_step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0080, 16'h0, sc);
    chk("t3_load_period", 16'(sc - prev), 16'd3);
    chk("t3_mdr", mdr, 16'hBEEF);
    chk("t3_pc", pc, 16'h0005);
    chk("t3_ir0", ir0q, 16'hA5A1);
    prev = sc;
    do_step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0080, 16'h5555, sc);
    chk("t3_store_period", 16'(sc - prev), 16'd3);
    chk("t3_mdr_kept", mdr, 16'hBEEF);
    chk("t3_stored", memv[16'h0080], 16'h5555);
    chk("t3_pc2", pc, 16'h0006);

    // Taken jump, then fetch from the target.
    memv[16'h0040] = 16'h4040;
    do_step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 16'h0, sc);
    chk("t4_pc", pc, 16'h0040);
    chk("t4_ir0", ir0q, 16'h0000);
    do_step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, sc);
    chk("t4_ir0_next", ir0q, 16'h4040);
    chk("t4_pc_next", pc, 16'h0041);

    // Bubble at pc 7, then refetch 7; wrap at FFFF.
    memv[7] = 16'h0707;
    do_step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0007, 16'h0, 16'h0, sc);
    do_step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, sc);
    chk("t5_clr_pc", pc, 16'h0007);
    chk("t5_clr_ir0", ir0q, 16'h0000);
    chk("t5_clr_ir1", ir1q, 16'h0000);
    do_step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, sc);
    chk("t5_refetch_ir0", ir0q, 16'h0707);
    chk("t5_refetch_pc", pc, 16'h0008);
    do_step(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0, 16'h0, sc);
    do_step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, sc);
    chk("t5_wrap_pc", pc, 16'h0000);
    chk("t5_wrap_ir0", ir0q, 16'h5A5A);

    // Timeout: no ack at all.
    do_reset();
    ack_en = 1'b0;
    ec = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_err === 1'b1) begin
        ec = cyc - t0 + 1;
        break;
      end
    end
    chk("t6_err_cycle", 16'(ec), 16'd17);
    repeat (3) begin
      @(negedge clk);
      chk("t6_err_req", {15'd0, mem_req}, 16'd0);
      chk("t6_err_step", {15'd0, step}, 16'd0);
      chk("t6_err_sticky", {15'd0, bus_err}, 16'd1);
    end

    // Ack exactly on the last allowed cycle.
    do_reset();
    ack_en = 1'b1;
    lat = 14;
    do_step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, sc);
    chk("t6_late_ok_cycle", 16'(sc), 16'd16);
    chk("t6_late_ok_err", {15'd0, bus_err}, 16'd0);
    chk("t6_late_ok_pc", pc, 16'h0001);

    // Reset mid-wait, with an ack arriving after the request has dropped.
    lat = 10;
    repeat (5) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1; ack_force = 1'b1;
    @(posedge clk); #2 reset = 1'b0; ack_force = 1'b0; lat = 0; t0 = cyc;
    @(negedge clk);
    chk("t7_req_dropped", {15'd0, mem_req}, 16'd0);
    chk("t7_pc", pc, 16'h0000);
    chk("t7_ir0", ir0q, 16'h0000);
    chk("t7_step", {15'd0, step}, 16'd0);
    @(posedge clk); #2;
    do_step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, sc);
    chk("t7_step_cycle", 16'(sc), 16'd2);
    chk("t7_pc_after", pc, 16'h0001);
    chk("t7_ir0_after", ir0q, 16'h1111);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
